// File: rtl/gpio_in.sv
// rtl/gpio_in.sv - debounced 8-bit GPIO input block with sticky rising-edge flags and level irq
module gpio_in #(
    parameter logic [31:0] BASE_ADDR  = 32'h0002_0010,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pins,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam logic [31:0] ADDR_DATA = BASE_ADDR;
    localparam logic [31:0] ADDR_EDGE = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_IEN  = BASE_ADDR + 32'd8;

    // Terminal count: a mismatch seen on this count is the DEB_CYCLES-th in a row.
    localparam logic [15:0] DEB_LAST  = 16'(DEB_CYCLES - 1);

    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [7:0]  stable;
    logic [7:0]  accept;
    logic [7:0]  rising;
    logic [7:0]  edge_flags;
    logic [7:0]  edge_clr;
    logic [7:0]  ien_reg;
    logic [31:0] rd_next;

    // Two-flop synchronizer; nothing downstream looks at pins directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    // One saturating-free debounce counter per bit; it restarts whenever the
    // synchronized level agrees with the accepted level, so only an unbroken
    // run of mismatches can reach the terminal count.
    for (genvar i = 0; i < 8; i++) begin : gen_deb
        logic [15:0] cnt;
        logic        differ;

        assign differ    = sync2[i] != stable[i];
        assign accept[i] = differ && (cnt == DEB_LAST);

        // Count consecutive mismatch cycles, clearing on agreement or acceptance.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= 16'd0;
            end else if (!differ || cnt == DEB_LAST) begin
                cnt <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // An accepted bit always flips, since acceptance implies a mismatch.
    assign rising   = accept & ~stable;
    assign edge_clr = (wr_en && addr == ADDR_EDGE) ? wr_data : 8'h00;

    // Accepted level register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 8'h00;
        end else begin
            stable <= stable ^ accept;
        end
    end

    // Sticky rising-edge flags; a new edge overrides a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_flags <= 8'h00;
        end else begin
            edge_flags <= (edge_flags & ~edge_clr) | rising;
        end
    end

    // Interrupt enable register, written by a store to its address only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ien_reg <= 8'h00;
        end else if (wr_en && addr == ADDR_IEN) begin
            ien_reg <= wr_data;
        end
    end

    // Registered level interrupt, lagging the flag/enable state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_flags & ien_reg);
        end
    end

    // Read mux on pre-edge register state; unmatched addresses read as zero.
    always_comb begin
        rd_next = 32'd0;
        if (addr == ADDR_DATA) begin
            rd_next = {24'd0, stable};
        end else if (addr == ADDR_EDGE) begin
            rd_next = {24'd0, edge_flags};
        end else if (addr == ADDR_IEN) begin
            rd_next = {24'd0, ien_reg};
        end
    end

    // Load result register; zero whenever the previous cycle had no load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 32'd0;
        end else if (rd_en) begin
            rd_data <= rd_next;
        end else begin
            rd_data <= 32'd0;
        end
    end

endmodule

// File: tb/tb_gpio_in.sv
// tb/tb_gpio_in.sv - self-checking bench for gpio_in with a window-based reference model
module tb_gpio_in;

    localparam logic [31:0] BASE = 32'h0002_0010;
    localparam int          DEB  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pins = 8'h00;
    logic [31:0] addr = 32'd0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [31:0] rd_data;
    logic        irq;

    int total  = 0;
    int passed = 0;

    gpio_in #(.BASE_ADDR(BASE), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .pins(pins), .addr(addr), .rd_en(rd_en),
        .wr_en(wr_en), .wr_data(wr_data), .rd_data(rd_data), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last DEB synchronized
    // samples all disagree with the accepted level.
    logic [7:0]  m_s1, m_s2, m_st, m_edge, m_ien;
    logic        m_irq;
    logic [31:0] m_rd;
    logic [7:0]  win[$];

    task automatic model_reset();
        m_s1 = 8'h00; m_s2 = 8'h00; m_st = 8'h00;
        m_edge = 8'h00; m_ien = 8'h00; m_irq = 1'b0; m_rd = 32'd0;
        win.delete();
    endtask

    task automatic model_edge();
        logic [7:0] st_new;
        logic [7:0] clr;
        logic       all_diff;
        st_new = m_st;
        win.push_back(m_s2);
        if (win.size() > DEB) void'(win.pop_front());
        if (win.size() == DEB) begin
            for (int b = 0; b < 8; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < win.size(); k++)
                    if (win[k][b] == m_st[b]) all_diff = 1'b0;
                if (all_diff) st_new[b] = ~m_st[b];
            end
        end
        if (!rd_en)                   m_rd = 32'd0;
        else if (addr == BASE)        m_rd = {24'd0, m_st};
        else if (addr == BASE + 4)    m_rd = {24'd0, m_edge};
        else if (addr == BASE + 8)    m_rd = {24'd0, m_ien};
        else                          m_rd = 32'd0;
        m_irq  = |(m_edge & m_ien);
        clr    = (wr_en && addr == BASE + 4) ? wr_data : 8'h00;
        m_edge = (m_edge & ~clr) | (st_new & ~m_st);
        if (wr_en && addr == BASE + 8) m_ien = wr_data;
        m_s2 = m_s1;
        m_s1 = pins;
        m_st = st_new;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("rd_data", rd_data, m_rd);
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        chk("stable", {24'd0, dut.stable}, {24'd0, m_st});
        chk("edge", {24'd0, dut.edge_flags}, {24'd0, m_edge});
        chk("ien", {24'd0, dut.ien_reg}, {24'd0, m_ien});
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all();
    endtask

    task automatic bus_idle();
        rd_en = 1'b0; wr_en = 1'b0; addr = 32'd0; wr_data = 8'h00;
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        step();
        rst = 1'b0;

        // Held level accepted after 2+DEB edges, then read back.
        pins = 8'h01;
        repeat (5) step();
        chk("deb_not_yet", {24'd0, dut.stable}, 32'h0);
        step();
        chk("deb_accept", {24'd0, dut.stable}, 32'h1);
        chk("deb_edge", {24'd0, dut.edge_flags}, 32'h1);
        addr = BASE; rd_en = 1'b1;
        step();
        bus_idle();
        chk("rd_stable", rd_data, 32'h1);
        step();
        chk("rd_idle_zero", rd_data, 32'h0);

        // Short glitch on bit 3 must not be accepted.
        pins = 8'h09;
        repeat (3) step();
        pins = 8'h01;
        repeat (6) step();
        chk("glitch_stable", {24'd0, dut.stable}, 32'h1);
        chk("glitch_edge", {24'd0, dut.edge_flags}, 32'h1);

        // Interrupt path: clear flags, drop bit 0, enable, raise bit 0.
        addr = BASE + 4; wr_data = 8'hFF; wr_en = 1'b1;
        step();
        bus_idle();
        pins = 8'h00;
        repeat (6) step();
        addr = BASE + 8; wr_data = 8'h01; wr_en = 1'b1;
        step();
        bus_idle();
        pins = 8'h01;
        repeat (6) step();
        chk("irq_lag", {31'd0, irq}, 32'h0);
        step();
        chk("irq_set", {31'd0, irq}, 32'h1);
        addr = BASE + 4; wr_data = 8'h01; wr_en = 1'b1;
        step();
        bus_idle();
        chk("w1c_edge", {24'd0, dut.edge_flags}, 32'h0);
        step();
        chk("irq_clear", {31'd0, irq}, 32'h0);

        // Clear and acceptance of bit 2 on the same edge: set wins.
        pins = 8'h05;
        repeat (5) step();
        addr = BASE + 4; wr_data = 8'h04; wr_en = 1'b1;
        step();
        bus_idle();
        chk("set_wins", {24'd0, dut.edge_flags}, 32'h4);

        // Unmapped and misaligned reads, then no strobe.
        addr = BASE + 12; rd_en = 1'b1;
        step();
        chk("rd_unmapped", rd_data, 32'h0);
        addr = BASE + 9;
        step();
        chk("rd_misaligned", rd_data, 32'h0);
        addr = BASE + 8;
        step();
        chk("rd_ien", rd_data, 32'h1);
        bus_idle();
        step();
        chk("rd_no_strobe", rd_data, 32'h0);

        // Reset in the middle of a debounce count.
        pins = 8'hFF;
        repeat (4) step();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_irq", {31'd0, irq}, 32'h0);
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("rst_restart", {24'd0, dut.stable}, 32'h0);
        step();
        chk("rst_accept", {24'd0, dut.stable}, 32'hFF);
        chk("rst_edge", {24'd0, dut.edge_flags}, 32'hFF);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(7) == 0) pins = pins ^ 8'($urandom);
            rd_en   = 1'($urandom);
            wr_en   = ($urandom_range(3) == 0);
            wr_data = 8'($urandom);
            case ($urandom_range(5))
                0: addr = BASE;
                1: addr = BASE + 4;
                2: addr = BASE + 8;
                3: addr = BASE + 12;
                4: addr = BASE + 32'($urandom_range(1, 3));
                default: addr = $urandom;
            endcase
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gpio_in.md
GPIO_IN -- requirements
Module: gpio_in

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0002_0010: byte address of the DATA register; EDGE is at BASE_ADDR+4, IEN at BASE_ADDR+8.
REQ-002 Parameter DEB_CYCLES, default 50000: consecutive synchronized cycles an input must differ before it is accepted (range 1..65535).
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 pins  input  8  raw asynchronous switch/button inputs.
REQ-007 addr  input  32  CPU byte address, valid alongside rd_en/wr_en.
REQ-008 rd_en  input  1  load strobe (ex stage).
REQ-009 wr_en  input  1  store strobe (ex stage).
REQ-010 wr_data  input  8  store data (low byte of the store value).
REQ-011 rd_data  output  32  load result, valid one cycle after rd_en (wb stage).
REQ-012 irq  output  1  level interrupt request.

Function
REQ-013 Each pins bit SHALL pass through a 2-flop synchronizer (sync1, then sync2) before any other use.
REQ-014 Per bit, an independent debounce counter (16 bit) SHALL clear to 0 whenever sync2 equals the stable bit.
REQ-015 While sync2 differs from stable, the counter SHALL increment each cycle; on the edge where the counter equals DEB_CYCLES-1 and the mismatch persists, stable SHALL take sync2 and the counter SHALL clear.
REQ-016 A pin level held constant SHALL therefore appear in stable exactly 2+DEB_CYCLES rising edges after it changes; a glitch shorter than DEB_CYCLES synchronized cycles SHALL never change stable.
REQ-017 The counter SHALL never wrap; it is bounded by DEB_CYCLES-1.
REQ-018 EDGE[i] SHALL be set on the same edge where stable[i] goes 0->1 and SHALL remain set (sticky) until cleared.
REQ-019 A store with wr_en=1 and addr==BASE_ADDR+4 SHALL clear every EDGE bit whose wr_data bit is 1 (write-1-to-clear).
REQ-020 If a set and a clear hit the same EDGE bit in the same cycle, the set SHALL win.
REQ-021 A store with wr_en=1 and addr==BASE_ADDR+8 SHALL load IEN from wr_data.
REQ-022 A store to DATA or to any other address SHALL be ignored.
REQ-023 irq SHALL be registered and SHALL equal |(EDGE & IEN) as of the previous edge, i.e. one cycle after the flag or enable changes.
REQ-024 rd_data SHALL be registered: at the edge with rd_en=1 it captures {24'd0,stable}, {24'd0,EDGE} or {24'd0,IEN} for addr equal to BASE_ADDR, +4 or +8 respectively, and 32'd0 for any other address.
REQ-025 rd_data SHALL be 32'd0 in every cycle not preceded by a valid rd_en.
REQ-026 The value returned SHALL be the register state before the edge, so a read coinciding with an update returns the old value.
REQ-027 Reads SHALL have no side effects; EDGE is not cleared by reading.
REQ-028 If rd_en and wr_en are both high, both SHALL be performed; the read returns the pre-write value.
REQ-029 Address compare SHALL be full 32-bit equality; misaligned addresses do not match.

Reset
REQ-030 While rst=1, asynchronously: sync1, sync2 and stable = 8'h00; counters = 0; EDGE = 8'h00; IEN = 8'h00; rd_data = 32'd0; irq = 0.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count; after release, counting restarts from 0 and stable is accepted only after a full 2+DEB_CYCLES edges.
REQ-032 A pin already high at reset release SHALL set EDGE when accepted, since stable resets to 0.

Verification (DEB_CYCLES=4)
REQ-033 Set pins=8'h01 and hold it -> stable[0]=1 at edge 6; a read of BASE_ADDR returns 32'h1 one cycle later; EDGE=8'h01.
REQ-034 Pulse pins[3]=1 for 3 cycles, then return it to 0 -> stable stays 8'h00 and EDGE stays 8'h00.
REQ-035 Set IEN=8'h01, then let pins[0] rise and be accepted -> irq=1 one cycle after EDGE[0] sets; store 8'h01 to BASE_ADDR+4 -> EDGE=0 and irq=0 on the following cycle.
REQ-036 Issue a clear of EDGE[2] on the same edge that pins[2] is accepted -> EDGE[2]=1 (set wins).
REQ-037 Read BASE_ADDR+12 -> rd_data=32'd0; then with no read strobe -> rd_data=32'd0.
REQ-038 Hold pins=8'hFF and assert rst for 1 cycle at count 2 -> all outputs and registers are 0; stable=8'hFF exactly 6 edges after release, with EDGE=8'hFF.
